// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the fetch/memory-stage RAM port arbiter.
package mem_port_arbiter_pkg;

    localparam int ADDR_W_DEF = 7;
    localparam int DATA_W_DEF = 32;

    localparam logic RAM_READ  = 1'b1;
    localparam logic RAM_WRITE = 1'b0;

    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        OWN_IF     = 2'b01,
        OWN_MEM_RD = 2'b10,
        OWN_MEM_WR = 2'b11
    } owner_e;

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating count of consecutive cycles in which fetch was denied the RAM.
module mem_port_arbiter_starve_counter #(
    parameter int MAX = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       i_clr,
    input  logic       i_inc,
    output logic [3:0] o_cnt,
    output logic       o_sat
);
    import mem_port_arbiter_pkg::*;

    logic [3:0] r_cnt;
    logic       w_sat;

    assign w_sat = (r_cnt == 4'(MAX));

    // Counter register: clear wins over increment, increment stops at MAX.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_cnt <= 4'd0;
        end else if (i_clr) begin
            r_cnt <= 4'd0;
        end else if (i_inc && !w_sat) begin
            r_cnt <= r_cnt + 4'd1;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_cnt = r_cnt;
    assign o_sat = w_sat;

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter between instruction fetch and the memory stage,
// with memory-stage priority and a starvation guard for fetch.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_stall,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_gnt,
    output logic              mem_rvalid,
    output logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wre,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    owner_e            r_owner;
    owner_e            w_owner_nxt;
    logic              w_if_gnt;
    logic              w_mem_gnt;
    logic              w_starve_clr;
    logic              w_starve_sat;
    logic [3:0]        w_starve_cnt;
    logic              r_if_rvalid;
    logic              r_mem_rvalid;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_mem_rdata;

    mem_port_arbiter_starve_counter #(
        .MAX (STARVE_MAX)
    ) u_starve (
        .clock (clock),
        .reset (reset),
        .i_clr (w_starve_clr),
        .i_inc (~w_starve_clr),
        .o_cnt (w_starve_cnt),
        .o_sat (w_starve_sat)
    );

    // Grant decision and next owner; grants are suppressed while in reset
    // so the RAM can never see a write during reset.
    always_comb begin
        w_if_gnt    = 1'b0;
        w_mem_gnt   = 1'b0;
        w_owner_nxt = IDLE;
        if (!reset) begin
            w_owner_nxt = IDLE;
        end else if (if_req && (!mem_req || w_starve_sat)) begin
            w_if_gnt    = 1'b1;
            w_owner_nxt = OWN_IF;
        end else if (mem_req) begin
            w_mem_gnt   = 1'b1;
            w_owner_nxt = mem_we ? OWN_MEM_WR : OWN_MEM_RD;
        end else begin
            w_owner_nxt = IDLE;
        end
    end

    assign w_starve_clr = ~if_req | w_if_gnt;

    // RAM drive follows the winner; idle port reads address 0.
    always_comb begin
        ram_addr  = '0;
        ram_wre   = RAM_READ;
        ram_wdata = '0;
        if (w_if_gnt) begin
            ram_addr = if_addr;
        end else if (w_mem_gnt) begin
            ram_addr = mem_addr;
            if (mem_we) begin
                ram_wre   = RAM_WRITE;
                ram_wdata = mem_wdata;
            end else begin
                ram_wre = RAM_READ;
            end
        end else begin
            ram_addr = '0;
        end
    end

    // Owner state and read responses; rdata holds while its rvalid is low.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_owner      <= IDLE;
            r_if_rvalid  <= 1'b0;
            r_mem_rvalid <= 1'b0;
            r_if_rdata   <= '0;
            r_mem_rdata  <= '0;
        end else begin
            r_owner      <= w_owner_nxt;
            r_if_rvalid  <= (w_owner_nxt == OWN_IF);
            r_mem_rvalid <= (w_owner_nxt == OWN_MEM_RD);
            if (w_owner_nxt == OWN_IF) begin
                r_if_rdata <= ram_rdata;
            end
            if (w_owner_nxt == OWN_MEM_RD) begin
                r_mem_rdata <= ram_rdata;
            end
        end
    end

    assign if_gnt     = w_if_gnt;
    assign mem_gnt    = w_mem_gnt;
    assign if_stall   = if_req & ~w_if_gnt;
    assign if_rvalid  = r_if_rvalid;
    assign if_rdata   = r_if_rdata;
    assign mem_rvalid = r_mem_rvalid;
    assign mem_rdata  = r_mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized bench for mem_port_arbiter against a cycle-level
// behavioural model with its own golden memory image.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int STARVE_MAX = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_req;
    logic [6:0]  if_addr;
    logic        if_gnt, if_stall, if_rvalid;
    logic [31:0] if_rdata;
    logic        mem_req, mem_we;
    logic [6:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;
    logic [6:0]  ram_addr;
    logic        ram_wre;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    mem_port_arbiter #(
        .ADDR_W     (7),
        .DATA_W     (32),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_stall   (if_stall),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .ram_addr   (ram_addr),
        .ram_wre    (ram_wre),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] init_val(input logic [6:0] a);
        return 32'hC0DE_0000 + ({25'd0, a} * 32'd4099);
    endfunction

    // Environment RAM: combinational read, write at the clock edge when ram_wre is low.
    logic [31:0] ram_mem [128];
    logic        ram_vld [128];
    logic        env_clr;

    assign ram_rdata = (ram_vld[ram_addr] === 1'b1) ? ram_mem[ram_addr] : init_val(ram_addr);

    always @(posedge clock) begin
        if (env_clr) begin
            for (int i = 0; i < 128; i++) ram_vld[i] <= 1'b0;
        end else if (ram_wre == 1'b0) begin
            ram_mem[ram_addr] <= ram_wdata;
            ram_vld[ram_addr] <= 1'b1;
        end
    end

    // Reference model state
    logic [31:0] gold [128];
    int          m_denied;
    logic        m_if_rv, m_mem_rv;
    logic [31:0] m_if_rd, m_mem_rd;
    logic [1:0]  m_owner;
    logic        last_if_gnt, last_mem_gnt;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic cycle(input logic rst, input logic ifr, input logic [6:0] ifa,
                         input logic mr, input logic mw, input logic [6:0] ma,
                         input logic [31:0] wd);
        logic        fw, mwin, st;
        logic [6:0]  ea;
        reset = rst; if_req = ifr; if_addr = ifa;
        mem_req = mr; mem_we = mw; mem_addr = ma; mem_wdata = wd;
        #3;
        fw   = rst && ifr && (!mr || m_denied >= STARVE_MAX);
        mwin = rst && mr && !fw;
        st   = mwin && mw;
        ea   = fw ? ifa : (mwin ? ma : 7'd0);
        chk("if_gnt",    32'(if_gnt),    32'(fw));
        chk("mem_gnt",   32'(mem_gnt),   32'(mwin));
        chk("if_stall",  32'(if_stall),  32'(ifr && !fw));
        chk("ram_addr",  32'(ram_addr),  32'(ea));
        chk("ram_wre",   32'(ram_wre),   32'(!st));
        chk("ram_wdata", ram_wdata,      st ? wd : 32'd0);
        last_if_gnt  = if_gnt;
        last_mem_gnt = mem_gnt;
        if (!rst) begin
            m_denied = 0;
            m_if_rv  = 1'b0; m_mem_rv = 1'b0;
            m_if_rd  = 32'd0; m_mem_rd = 32'd0;
            m_owner  = IDLE;
        end else begin
            if (ifr && !fw) m_denied = (m_denied < STARVE_MAX) ? m_denied + 1 : STARVE_MAX;
            else            m_denied = 0;
            m_if_rv  = fw;
            if (fw) m_if_rd = gold[ifa];
            m_mem_rv = mwin && !mw;
            if (m_mem_rv) m_mem_rd = gold[ma];
            if (st) gold[ma] = wd;
            m_owner = fw ? OWN_IF : (mwin ? (mw ? OWN_MEM_WR : OWN_MEM_RD) : IDLE);
        end
        @(posedge clock);
        #1;
        chk("if_rvalid",  32'(if_rvalid),        32'(m_if_rv));
        chk("if_rdata",   if_rdata,              m_if_rd);
        chk("mem_rvalid", 32'(mem_rvalid),       32'(m_mem_rv));
        chk("mem_rdata",  mem_rdata,             m_mem_rd);
        chk("owner",      32'(dut.r_owner),      32'(m_owner));
        chk("starve_cnt", 32'(dut.w_starve_cnt), 32'(m_denied));
    endtask

    initial begin
        for (int i = 0; i < 128; i++) gold[i] = init_val(7'(i));
        m_denied = 0; m_if_rv = 1'b0; m_mem_rv = 1'b0;
        m_if_rd = 32'd0; m_mem_rd = 32'd0; m_owner = IDLE;
        reset = 1'b0; if_req = 1'b0; if_addr = 7'd0;
        mem_req = 1'b0; mem_we = 1'b0; mem_addr = 7'd0; mem_wdata = 32'd0;
        env_clr = 1'b1;
        @(posedge clock);
        #1;
        env_clr = 1'b0;

        // Reset with a store request pending: no write, no grants.
        cycle(1'b0, 1'b1, 7'h01, 1'b1, 1'b1, 7'h01, 32'hBAD0_0001);
        cycle(1'b0, 1'b0, 7'h00, 1'b0, 1'b0, 7'h00, 32'h0);

        // Store DEADBEEF to word 5, then fetch it back.
        cycle(1'b1, 1'b0, 7'h00, 1'b1, 1'b1, 7'h05, 32'hDEAD_BEEF);
        cycle(1'b1, 1'b1, 7'h05, 1'b0, 1'b0, 7'h00, 32'h0);
        chk("fetch_gnt_n", 32'(last_if_gnt), 32'd1);
        chk("fetch_rdata", if_rdata, 32'hDEAD_BEEF);

        // Store then load of 0x10.
        cycle(1'b1, 1'b0, 7'h00, 1'b1, 1'b1, 7'h10, 32'h1234_5678);
        chk("store_no_rvalid", 32'(mem_rvalid), 32'd0);
        cycle(1'b1, 1'b0, 7'h00, 1'b1, 1'b0, 7'h10, 32'h0);
        chk("load_rdata", mem_rdata, 32'h1234_5678);

        // Continuous contention: memory wins four cycles, fetch the fifth, memory again.
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 1'b1, 7'h05, 1'b1, 1'b0, 7'h10, 32'h0);
            chk("starve_if_gnt", 32'(last_if_gnt), (i == 4) ? 32'd1 : 32'd0);
            chk("starve_mem_gnt", 32'(last_mem_gnt), (i == 4) ? 32'd0 : 32'd1);
        end
        cycle(1'b1, 1'b0, 7'h00, 1'b0, 1'b0, 7'h00, 32'h0);

        // Load granted, then reset with a store request asserted.
        cycle(1'b1, 1'b0, 7'h00, 1'b1, 1'b0, 7'h10, 32'h0);
        cycle(1'b0, 1'b1, 7'h22, 1'b1, 1'b1, 7'h22, 32'hFFFF_FFFF);
        chk("rst_drop_rvalid", 32'(mem_rvalid), 32'd0);
        cycle(1'b1, 1'b1, 7'h22, 1'b0, 1'b0, 7'h00, 32'h0);
        chk("rst_no_write", if_rdata, init_val(7'h22));

        // Idle stretch.
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 7'h00, 1'b0, 1'b0, 7'h00, 32'h0);

        // Randomized traffic over a small address window.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 39) != 0),
                  ($urandom_range(0, 9) < 6), 7'($urandom_range(0, 15)),
                  ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 4),
                  7'($urandom_range(0, 15)), $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported instruction/data RAM between the fetch stage (instruction reads) and the memory stage (loads/stores).
- Decides the owner of the RAM every cycle, drives the RAM address, read/write select and write-data lines, and registers the read data back to the winner.
- Generates if_stall for the fetch stage.
- Default priority goes to the memory stage, which holds the older instruction. A starvation counter guarantees forward progress for fetch.

Parameters:
- ADDR_W, 7, RAM word-address width.
- DATA_W, 32, RAM word width.
- STARVE_MAX, 4, consecutive denied fetch cycles after which fetch is forced to win (legal range 1..15).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- if_req  in  1  fetch requests an instruction read this cycle.
- if_addr  in  ADDR_W  fetch word address.
- if_gnt  out  1  fetch owns the RAM this cycle (combinational).
- if_stall  out  1  if_req & ~if_gnt; fetch holds its pc.
- if_rvalid  out  1  if_rdata is valid (registered).
- if_rdata  out  DATA_W  instruction word (registered).
- mem_req  in  1  memory stage requests an access.
- mem_we  in  1  1 = store, 0 = load.
- mem_addr  in  ADDR_W  data word address.
- mem_wdata  in  DATA_W  store data.
- mem_gnt  out  1  memory stage owns the RAM this cycle (combinational).
- mem_rvalid  out  1  mem_rdata is valid; loads only (registered).
- mem_rdata  out  DATA_W  load data (registered).
- ram_addr  out  ADDR_W  RAM address.
- ram_wre  out  1  RAM select: 1 = read, 0 = write.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data, valid in the same cycle as the address.

Behaviour:
- Grant is combinational, from the current requests and starve_cnt. At most one of if_gnt and mem_gnt is high in any cycle.
- Arbitration rules, in order:
  - Only one requester active: that requester wins.
  - Both active and starve_cnt == STARVE_MAX: fetch wins.
  - Both active otherwise: memory stage wins.
  - Neither active: no grant. ram_addr = 0, ram_wre = 1.
- RAM drive while granted:
  - Fetch granted: ram_addr = if_addr, ram_wre = 1.
  - Memory stage granted: ram_addr = mem_addr, ram_wre = ~mem_we, ram_wdata = mem_wdata.
  - ram_wdata = 0 whenever no store is granted.
- Response latency is 1 cycle. A grant in cycle N registers ram_rdata into the winner's rdata register and pulses that rvalid in cycle N+1.
  - Stores produce no mem_rvalid.
  - rdata registers hold their last value when rvalid is low.
- starve_cnt (4-bit) is updated each edge:
  - Cleared if ~if_req or if_gnt.
  - Otherwise incremented, saturating at STARVE_MAX.
  - It therefore reaches STARVE_MAX after STARVE_MAX denied cycles, and fetch wins on the following contended cycle.
- owner register (FSM states IDLE, OWN_IF, OWN_MEM_RD, OWN_MEM_WR) records the previous cycle's grant. It drives the rvalid pulses and is visible for debug.
  - Transitions follow the grant each cycle.
  - A cycle with no grant goes to IDLE.
- A store granted in cycle N is visible to any read of the same address in cycle N+1 or later. A fetch and a store to the same address cannot occur in the same cycle, because the grants are exclusive.
- Requests need not be held. A denied requester re-presents its request, and if_stall tells fetch to hold.
- Reset (reset == 0 at a rising edge) sets:
  - owner = IDLE, starve_cnt = 0.
  - if_rvalid = 0, mem_rvalid = 0, if_rdata = 0, mem_rdata = 0.
- Grants and RAM drive remain combinational during reset, so the RAM must not be written while reset is asserted: during reset the block forces mem_gnt = 0, if_gnt = 0 and ram_wre = 1.
- A response in flight when reset asserts is dropped. No rvalid appears after reset releases unless a new grant occurs.

Decomposition:
- Shared package holds:
  - owner state encoding (IDLE = 2'b00, OWN_IF = 2'b01, OWN_MEM_RD = 2'b10, OWN_MEM_WR = 2'b11).
  - RAM select constants RAM_READ = 1'b1, RAM_WRITE = 1'b0.
  - ADDR_W and DATA_W defaults.
- One sub-module is natural: starve_counter (saturating counter with clear, increment and sat flag).

Test Plan:
- Fetch-only: if_req = 1, if_addr = 7'h05, RAM[5] = 32'hDEAD_BEEF → if_gnt = 1 and if_stall = 0 in cycle N; if_rvalid = 1 and if_rdata = 32'hDEAD_BEEF in cycle N+1.
- Store then load: cycle N mem_req = 1, mem_we = 1, addr 7'h10, wdata 32'h1234_5678 (ram_wre = 0, no mem_rvalid in N+1); cycle N+1 load of 7'h10 → mem_rvalid in N+2 with 32'h1234_5678.
- Contention: both request for 3 cycles, STARVE_MAX = 4 → mem_gnt every cycle; if_stall = 1 throughout; no if_rvalid.
- Starvation: both request continuously, STARVE_MAX = 4 → mem wins cycles 0-3, fetch wins cycle 4; starve_cnt = 0 after the fetch grant; mem wins cycle 5.
- Reset mid-operation: load granted in cycle N, reset = 0 at edge N+1 → mem_rvalid = 0 at N+1; starve_cnt = 0; ram_wre = 1 and both grants 0 while reset is low, even with mem_req = mem_we = 1 asserted.
- Idle: no requests for 10 cycles → ram_wre = 1, ram_addr = 0, both rvalid = 0, owner = IDLE.
